ds1302_responder: RTL and testbench

Synthesizable DS1302-compatible serial responder: the device end of the 3-wire CE/SCLK/IO link driven by the team's DS1302 master controller. It oversamples the link on the system clock, decodes the LSB-first command byte, and stores written bytes into a 64-entry register file or shifts register bytes back out for reads. Used as an on-FPGA RTC stand-in for bring-up, and as a loopback target for master-side verification.

---
 rtl/ds1302_pkg.sv | 35 +++
 rtl/ds1302_edge_sync.sv | 40 ++++
 rtl/ds1302_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_ds1302_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds1302_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ds1302_pkg
//  Description : Shared types and constants for the DS1302-compatible
//                serial responder (FSM states, command-byte fields,
//                register-file geometry).
//  Revision    : 1.0  initial release
// ============================================================================
package ds1302_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_WDATA = 3'd2,
        ST_RDATA = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Command-byte bit positions (byte arrives LSB first)
    localparam int CMD_RW_BIT    = 0;
    localparam int CMD_RAM_BIT   = 6;
    localparam int CMD_VALID_BIT = 7;

    // Register holding the write-protect flag in its bit 7
    localparam logic [5:0] ADDR_WP = 6'd7;

    localparam int REGFILE_DEPTH = 64;

    // Register-file index of a command byte: {RAM/CK, A4..A0}
    function automatic logic [5:0] cmd_index(input logic [7:0] cmd);
        return {cmd[CMD_RAM_BIT], cmd[5:1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ds1302_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ds1302_edge_sync
//  Description : Two-flop synchronizer for an asynchronous pad input with
//                rise/fall detection against one registered copy of the
//                synchronized value.
//  Revision    : 1.0  initial release
// ============================================================================
module ds1302_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev;

    // Two-stage synchronizer followed by the edge-detect history register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev   <= 1'b0;
        end else begin
            meta   <= pad;
            sync_q <= meta;
            prev   <= sync_q;
        end
    end

    assign sync = sync_q;
    assign rise = sync_q & ~prev;
    assign fall = ~sync_q & prev;

endmodule
`default_nettype wire

// File: rtl/ds1302_responder.sv
`default_nettype none
// ============================================================================
//  Module      : ds1302_responder
//  Description : Device end of the DS1302 3-wire CE/SCLK/IO link. Decodes an
//                LSB-first command byte, commits written bytes into a 64x8
//                register file and shifts register bytes back out for reads.
//                Optional macro DS1302_WP_EN: regfile[7] bit 7 acts as write
//                protect for every other register.
//  Revision    : 1.0  initial release
// ============================================================================
module ds1302_responder
    import ds1302_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic       sclk,
    input  logic       io_in,
    output logic       io_out,
    output logic       io_oe,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_strobe,
    input  logic [5:0] host_addr,
    output logic [7:0] host_rdata
);

    // ------------------------------------------------------------------
    // Pad synchronization
    // ------------------------------------------------------------------
    logic ce_s, io_s;
    logic sclk_s_unused, sclk_rise, sclk_fall;
    logic ce_rise_unused, ce_fall_unused;
    logic io_rise_unused, io_fall_unused;

    ds1302_edge_sync u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .pad  (sclk),
        .sync (sclk_s_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    ds1302_edge_sync u_ce_sync (
        .clk  (clk),
        .rst  (rst),
        .pad  (ce),
        .sync (ce_s),
        .rise (ce_rise_unused),
        .fall (ce_fall_unused)
    );

    ds1302_edge_sync u_io_sync (
        .clk  (clk),
        .rst  (rst),
        .pad  (io_in),
        .sync (io_s),
        .rise (io_rise_unused),
        .fall (io_fall_unused)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  shift, shift_n;
    logic [5:0]  cmd_idx, cmd_idx_n;
    logic [7:0]  tx, tx_n;
    logic        tx_done, tx_done_n;
    logic        io_out_n, io_oe_n;
    logic        wr_strobe_n, rd_strobe_n;
    logic [5:0]  wr_addr_n;
    logic [7:0]  wr_data_n;
    logic        commit;
    logic [7:0]  rx_byte;
    logic        wp_block;

    logic [7:0]  regfile [REGFILE_DEPTH];

`ifdef DS1302_WP_EN
    // The WP register itself stays writable so protection can be lifted
    assign wp_block = regfile[ADDR_WP][7] && (cmd_idx != ADDR_WP);
`else
    assign wp_block = 1'b0;
`endif

    assign host_rdata = regfile[host_addr];

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state, datapath next values and strobes
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        cmd_idx_n   = cmd_idx;
        tx_n        = tx;
        tx_done_n   = tx_done;
        io_out_n    = io_out;
        io_oe_n     = io_oe;
        wr_strobe_n = 1'b0;
        rd_strobe_n = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        commit      = 1'b0;

        // Current byte with the bit being sampled this cycle merged in
        rx_byte          = shift;
        rx_byte[bit_cnt] = io_s;

        if (!ce_s) begin
            // CE low aborts anything in flight; partial bytes are dropped
            state_n = ST_IDLE;
            io_oe_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt_n = 3'd0;
                    tx_done_n = 1'b0;
                    state_n   = ST_CMD;
                end

                ST_CMD: begin
                    if (sclk_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            cmd_idx_n = cmd_index(rx_byte);
                            if (!rx_byte[CMD_VALID_BIT]) begin
                                state_n = ST_DONE;
                            end else if (rx_byte[CMD_RW_BIT]) begin
                                tx_n        = regfile[cmd_index(rx_byte)];
                                tx_done_n   = 1'b0;
                                rd_strobe_n = 1'b1;
                                state_n     = ST_RDATA;
                            end else begin
                                state_n = ST_WDATA;
                            end
                        end
                    end
                end

                ST_WDATA: begin
                    if (sclk_rise) begin
                        shift_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (!wp_block) begin
                                commit      = 1'b1;
                                wr_strobe_n = 1'b1;
                                wr_addr_n   = cmd_idx;
                                wr_data_n   = rx_byte;
                            end
                            state_n = ST_DONE;
                        end
                    end
                end

                ST_RDATA: begin
                    if (sclk_fall) begin
                        if (!tx_done) begin
                            io_out_n  = tx[bit_cnt];
                            io_oe_n   = 1'b1;
                            bit_cnt_n = bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                tx_done_n = 1'b1;
                            end
                        end else begin
                            // Release the bus on the fall after the last bit
                            io_oe_n = 1'b0;
                            state_n = ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    io_oe_n = 1'b0;
                end

                default: begin
                    state_n = ST_IDLE;
                    io_oe_n = 1'b0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            cmd_idx   <= 6'd0;
            tx        <= 8'h00;
            tx_done   <= 1'b0;
            io_out    <= 1'b0;
            io_oe     <= 1'b0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            wr_addr   <= 6'd0;
            wr_data   <= 8'h00;
        end else begin
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            cmd_idx   <= cmd_idx_n;
            tx        <= tx_n;
            tx_done   <= tx_done_n;
            io_out    <= io_out_n;
            io_oe     <= io_oe_n;
            wr_strobe <= wr_strobe_n;
            rd_strobe <= rd_strobe_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
        end
    end

    // Register file: cleared by reset, written on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REGFILE_DEPTH; i++) begin
                regfile[i] <= 8'h00;
            end
        end else if (commit) begin
            regfile[wr_addr_n] <= wr_data_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ds1302_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ds1302_responder
//  Description : Self-checking bench for ds1302_responder. Table of link
//                transactions plus hand-written abort, invalid-command and
//                reset-during-read sequences; commits checked by scoreboard.
//                Honours DS1302_WP_EN when the design is built with it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ds1302_responder;
    import ds1302_pkg::*;

    localparam int HALF = 6;  // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       sclk = 1'b0;
    logic       io_in = 1'b0;
    logic       io_out;
    logic       io_oe;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_strobe;
    logic [5:0] host_addr = 6'd0;
    logic [7:0] host_rdata;

    ds1302_responder dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .sclk       (sclk),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_strobe  (rd_strobe),
        .host_addr  (host_addr),
        .host_rdata (host_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic oe_seen = 1'b0;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_exp_t;
    wr_exp_t sb[$];
    wr_exp_t sb_e;

    logic [7:0] mem [64];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic       commit;
        logic [7:0] rd_exp;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Commit scoreboard and strobe/oe monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=%02h expected no commit", wr_addr, wr_data);
            end else begin
                sb_e = sb.pop_front();
                check("wr_commit", {18'd0, wr_addr, wr_data}, {18'd0, sb_e.addr, sb_e.data});
            end
        end
        if (!rst && rd_strobe) rd_cnt++;
        if (io_oe) oe_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        io_in = b;
        tick(HALF);
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] data);
        ce = 1'b1;
        tick(4);
        send_byte(cmd);
        send_byte(data);
        ce = 1'b0;
        tick(6);
    endtask

    task automatic do_read(input logic [7:0] cmd, output logic [7:0] got,
                           output logic oe_all, output logic oe_after);
        ce = 1'b1;
        tick(4);
        send_byte(cmd);
        got[0] = io_out;
        oe_all = io_oe;
        for (int i = 1; i < 8; i++) begin
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
            tick(HALF);
            got[i] = io_out;
            oe_all = oe_all & io_oe;
        end
        sclk = 1'b1;
        tick(HALF);
        sclk = 1'b0;
        tick(HALF);
        oe_after = io_oe;
        ce = 1'b0;
        tick(6);
    endtask

    initial begin
        logic [7:0] got;
        logic       oe_all, oe_after;
        int         w0, r0;
        logic [5:0] idx;

        for (int i = 0; i < 64; i++) mem[i] = 8'h00;

        vecs[0]  = '{8'h80, 8'h59, 1'b1, 8'h00};
        vecs[1]  = '{8'h81, 8'h00, 1'b0, 8'h59};
        vecs[2]  = '{8'hCA, 8'hA5, 1'b1, 8'h00};
        vecs[3]  = '{8'hCB, 8'h00, 1'b0, 8'hA5};
        vecs[4]  = '{8'hBE, 8'h3C, 1'b1, 8'h00};
        vecs[5]  = '{8'hBF, 8'h00, 1'b0, 8'h3C};
        vecs[6]  = '{8'hFE, 8'hFF, 1'b1, 8'h00};
        vecs[7]  = '{8'hFF, 8'h00, 1'b0, 8'hFF};
        vecs[8]  = '{8'h8E, 8'h80, 1'b1, 8'h00};
`ifdef DS1302_WP_EN
        vecs[9]  = '{8'h80, 8'h12, 1'b0, 8'h00};
        vecs[10] = '{8'h81, 8'h00, 1'b0, 8'h59};
`else
        vecs[9]  = '{8'h80, 8'h12, 1'b1, 8'h00};
        vecs[10] = '{8'h81, 8'h00, 1'b0, 8'h12};
`endif
        vecs[11] = '{8'h8E, 8'h00, 1'b1, 8'h00};
        vecs[12] = '{8'h82, 8'h66, 1'b1, 8'h00};
        vecs[13] = '{8'h83, 8'h00, 1'b0, 8'h66};

        // Reset state
        tick(3);
        rst = 1'b0;
        tick(3);
        check("rst_io_out", {31'd0, io_out}, 32'd0);
        check("rst_io_oe", {31'd0, io_oe}, 32'd0);
        check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
        check("rst_wr_addr", {26'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        host_addr = 6'd0;  #1; check("rst_reg0", {24'd0, host_rdata}, 32'd0);
        host_addr = 6'd37; #1; check("rst_reg37", {24'd0, host_rdata}, 32'd0);
        host_addr = 6'd63; #1; check("rst_reg63", {24'd0, host_rdata}, 32'd0);

        // Table-driven transactions
        for (int v = 0; v < 14; v++) begin
            idx = {vecs[v].cmd[6], vecs[v].cmd[5:1]};
            if (vecs[v].cmd[0]) begin
                r0 = rd_cnt;
                do_read(vecs[v].cmd, got, oe_all, oe_after);
                check("rd_data", {24'd0, got}, {24'd0, vecs[v].rd_exp});
                check("rd_oe_during", {31'd0, oe_all}, 32'd1);
                check("rd_oe_after_9th_fall", {31'd0, oe_after}, 32'd0);
                check("rd_strobe_count", rd_cnt - r0, 32'd1);
            end else begin
                if (vecs[v].commit) begin
                    sb.push_back({idx, vecs[v].data});
                    mem[idx] = vecs[v].data;
                end
                w0 = wr_cnt;
                do_write(vecs[v].cmd, vecs[v].data);
                check("wr_strobe_count", wr_cnt - w0, {31'd0, vecs[v].commit});
                host_addr = idx;
                #1;
                check("host_rdata", {24'd0, host_rdata}, {24'd0, mem[idx]});
            end
        end

        // CE dropped after 4 data bits: nothing committed, back to IDLE
        w0 = wr_cnt;
        ce = 1'b1;
        tick(4);
        send_byte(8'h80);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        ce = 1'b0;
        tick(4);
        check("abort_idle", {31'd0, dut.state == ST_IDLE}, 32'd1);
        tick(4);
        check("abort_no_strobe", wr_cnt - w0, 32'd0);
        host_addr = 6'd0;
        #1;
        check("abort_reg0", {24'd0, host_rdata}, {24'd0, mem[0]});

        // Command without bit 7: responder stays silent
        w0 = wr_cnt;
        r0 = rd_cnt;
        oe_seen = 1'b0;
        ce = 1'b1;
        tick(4);
        send_byte(8'h01);
        send_byte(8'h55);
        ce = 1'b0;
        tick(6);
        check("invalid_oe", {31'd0, oe_seen}, 32'd0);
        check("invalid_wr", wr_cnt - w0, 32'd0);
        check("invalid_rd", rd_cnt - r0, 32'd0);
        check("invalid_reg0", {24'd0, host_rdata}, {24'd0, mem[0]});

        // Reset during a read: io_oe drops immediately, regfile clears
        ce = 1'b1;
        tick(4);
        send_byte(8'h83);
        send_bit(1'b0);
        send_bit(1'b0);
        check("rdata_oe_before_rst", {31'd0, io_oe}, 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_oe", {31'd0, io_oe}, 32'd0);
        ce = 1'b0;
        sclk = 1'b0;
        for (int a = 0; a < 64; a++) begin
            host_addr = 6'(a);
            #1;
            check("rst_clear", {24'd0, host_rdata}, 32'd0);
        end
        tick(2);
        rst = 1'b0;
        tick(4);

        check("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop guard against a stalled run
    initial begin
        #2000000;
        $display("FAIL timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
